// File: rtl/kim_display_keypad_pkg.sv
// kim_pkg: shared constants and types for the KIM-1 display/keypad board model.
package kim_pkg;

  localparam int         NUM_DIGITS     = 6;
  localparam logic [3:0] DIGIT_SEL_BASE = 4'd4;
  localparam int         KEY_ROWS       = 3;
  localparam int         KEY_COLS       = 7;
  localparam int         NUM_KEYS       = KEY_ROWS * KEY_COLS;
  localparam logic [3:0] SEL_TTY        = 4'd3;
  localparam logic [3:0] SEL_NONE       = 4'hF;
  localparam logic [3:0] DIGIT_SEL_LAST = DIGIT_SEL_BASE + 4'(NUM_DIGITS - 1);

  typedef logic [6:0] seg_t;

  // True when a scan select addresses one of the six display digits.
  function automatic logic is_digit_sel(input logic [3:0] sel);
    return (sel >= DIGIT_SEL_BASE) && (sel <= DIGIT_SEL_LAST);
  endfunction

endpackage

// File: rtl/kim_display_keypad_debounce.sv
// debounce_vec: two-flop synchroniser followed by a single counter shared by
// every bit; the whole vector must hold still for CYCLES cycles before the
// debounced copy is refreshed.
module debounce_vec #(
  parameter int WIDTH  = 22,
  parameter int CYCLES = 5000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int            CW      = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Restart the quiet-period count on any movement; load once it saturates.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_MAX) begin
      stable_d = sync2_q;
    end
  end

  // Synchroniser, previous-sample register, counter and debounced state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/kim_display_keypad.sv
// kim_display_keypad: board-side partner of the 6530 I/O port. Decodes the
// scan select, latches multiplexed segment patterns into a fading frame
// buffer, debounces the key matrix and returns the selected key row on PA.
module kim_display_keypad
  import kim_pkg::*;
#(
  parameter int CAPTURE_CYCLES  = 4,
  parameter int PERSIST_CYCLES  = 20000,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic        phi2,
  input  logic        rst_n,
  input  logic [7:0]  PAO,
  input  logic [7:0]  DDRA,
  input  logic [7:0]  PBO,
  input  logic [7:0]  DDRB,
  output logic [7:0]  PAI,
  input  logic [20:0] key_raw,
  input  logic        tty_jumper,
  input  logic        ser_rx,
  output logic [41:0] digit_seg,
  output logic [5:0]  digit_lit,
  output logic [20:0] key_stable
);

  localparam int            DW           = $clog2(CAPTURE_CYCLES + 1);
  localparam int            PW           = $clog2(PERSIST_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_MAX    = DW'(CAPTURE_CYCLES);
  localparam logic [DW-1:0] DWELL_FIRE   = DW'(CAPTURE_CYCLES - 1);
  localparam logic [PW-1:0] PERSIST_LOAD = PW'(PERSIST_CYCLES);
  localparam logic [PW-1:0] PERSIST_LAST = PW'(1);

  logic [3:0]                    sel, sel_q, digit_idx;
  logic                          capture;
  logic [DW-1:0]                 dwell_q, dwell_d;
  logic [NUM_DIGITS-1:0][PW-1:0] persist_q, persist_d;
  logic [NUM_DIGITS-1:0]         lit_q, lit_d;
  seg_t [NUM_DIGITS-1:0]         seg_q, seg_d;
  logic [NUM_KEYS:0]             db_stable;
  logic                          tty_stable;
  logic [KEY_ROWS-1:0][KEY_COLS-1:0] key_rows;
  logic [KEY_COLS-1:0]           row_term;
  logic [7:0]                    pai_d, pai_q;
  logic                          ser_sync1_q, ser_sync2_q;
  logic                          unused_bits;

  // Only a fully-driven PB[4:1] counts as a select; anything else is idle.
  assign sel       = (DDRB[4:1] == 4'hF) ? PBO[4:1] : SEL_NONE;
  assign digit_idx = sel - DIGIT_SEL_BASE;
  assign unused_bits = ^{PBO[7:5], PBO[0], DDRB[7:5], DDRB[0]};

  // Dwell counting, single capture per dwell, and per-digit fade timers.
  always_comb begin
    dwell_d = dwell_q;
    if (sel != sel_q) begin
      dwell_d = '0;
    end else if (dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + 1'b1;
    end
    capture   = (dwell_d == DWELL_FIRE) && is_digit_sel(sel);
    persist_d = persist_q;
    lit_d     = lit_q;
    seg_d     = seg_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (capture && (digit_idx == 4'(d))) begin
        seg_d[d]     = PAO[6:0] & DDRA[6:0];
        lit_d[d]     = 1'b1;
        persist_d[d] = PERSIST_LOAD;
      end else if (persist_q[d] != '0) begin
        persist_d[d] = persist_q[d] - 1'b1;
        if (persist_q[d] == PERSIST_LAST) begin
          lit_d[d] = 1'b0;
          seg_d[d] = '0;
        end
      end
    end
  end

  // Frame buffer state and scan tracking registers.
  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SEL_NONE;
      dwell_q   <= '0;
      persist_q <= '0;
      lit_q     <= '0;
      seg_q     <= '0;
    end else begin
      sel_q     <= sel;
      dwell_q   <= dwell_d;
      persist_q <= persist_d;
      lit_q     <= lit_d;
      seg_q     <= seg_d;
    end
  end

  debounce_vec #(
    .WIDTH  (NUM_KEYS + 1),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i    (phi2),
    .rst_ni   (rst_n),
    .raw_i    ({tty_jumper, key_raw}),
    .stable_o (db_stable)
  );

  assign key_stable = db_stable[NUM_KEYS-1:0];
  assign tty_stable = db_stable[NUM_KEYS];
  assign key_rows   = db_stable[NUM_KEYS-1:0];

  // Key rows pull PA low (open collector) against whatever the 6530 drives.
  always_comb begin
    row_term = '1;
    if (sel < 4'(KEY_ROWS)) begin
      row_term = ~key_rows[sel[1:0]];
    end else if (sel == SEL_TTY) begin
      row_term = {6'h3F, ~tty_stable};
    end
    pai_d = {(DDRA[7] ? PAO[7] : ser_sync2_q), ((PAO[6:0] | ~DDRA[6:0]) & row_term)};
  end

  // Serial-line synchroniser and the registered PA return path.
  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      ser_sync1_q <= 1'b1;
      ser_sync2_q <= 1'b1;
      pai_q       <= 8'hFF;
    end else begin
      ser_sync1_q <= ser_rx;
      ser_sync2_q <= ser_sync1_q;
      pai_q       <= pai_d;
    end
  end

  assign digit_seg = seg_q;
  assign digit_lit = lit_q;
  assign PAI       = pai_q;

endmodule
